// File: rtl/hdlc_protocol_monitor_pkg.sv
// Shared definitions for the HDLC protocol monitor: check codes and the flag octet.
package hdlc_mon_pkg;

  typedef enum logic [1:0] {
    FLAG  = 2'd0,
    ABORT = 2'd1,
    IDLE  = 2'd2
  } err_code;

  localparam int unsigned NUM_CHECKS   = 3;
  localparam logic [7:0]  FLAG_PATTERN = 8'b0111_1110;

endpackage

// File: rtl/hdlc_protocol_monitor_if.sv
// Observed HDLC receive/transmit signals of the design under monitor, one bit per channel.
interface hdlc_protocol_monitor_if #(
  parameter int unsigned NUM_CH = 4
);

  logic [NUM_CH-1:0] Rx;
  logic [NUM_CH-1:0] Rx_FlagDetect;
  logic [NUM_CH-1:0] Rx_ValidFrame;
  logic [NUM_CH-1:0] Rx_AbortDetect;
  logic [NUM_CH-1:0] Rx_AbortSignal;
  logic [NUM_CH-1:0] Tx;
  logic [NUM_CH-1:0] Tx_ValidFrame;

  modport master (
    output Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal, Tx, Tx_ValidFrame
  );

  modport slave (
    input Rx, Rx_FlagDetect, Rx_ValidFrame, Rx_AbortDetect, Rx_AbortSignal, Tx, Tx_ValidFrame
  );

endinterface

// File: rtl/hdlc_protocol_monitor_ch.sv
// Per-channel checks: flag latency, abort status follow-up and Tx idle level.
module hdlc_mon_ch
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned FLAG_LAT = 2,
  parameter int unsigned IDLE_LEN = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NUM_CHECKS-1:0] ChkEn,
  input  logic                  Rx,
  input  logic                  Rx_FlagDetect,
  input  logic                  Rx_ValidFrame,
  input  logic                  Rx_AbortDetect,
  input  logic                  Rx_AbortSignal,
  input  logic                  Tx,
  input  logic                  Tx_ValidFrame,
  output logic [NUM_CHECKS-1:0] ErrDet
);

  localparam logic [7:0] IDLE_MAX = 8'(IDLE_LEN);

  logic [7:0]          rxHist;
  logic [7:0]          rxNext;
  logic                flagMatch;
  logic [FLAG_LAT-1:0] flagPend;
  logic                abortArm;
  logic [7:0]          idleCnt;

  // The match includes the bit on Rx this cycle, so latency counts from the last flag bit.
  always_comb begin
    rxNext    = {rxHist[6:0], Rx};
    flagMatch = (rxNext == FLAG_PATTERN);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rxHist   <= '1;
      flagPend <= '0;
      abortArm <= 1'b0;
      idleCnt  <= '0;
    end else begin
      rxHist      <= rxNext;
      flagPend[0] <= flagMatch;
      for (int unsigned i = 1; i < FLAG_LAT; i++) begin
        flagPend[i] <= flagPend[i-1];
      end
      abortArm <= Rx_AbortDetect & Rx_ValidFrame;
      if (Tx_ValidFrame) begin
        idleCnt <= '0;
      end else if (idleCnt != IDLE_MAX) begin
        idleCnt <= idleCnt + 8'd1;
      end
    end
  end

  always_comb begin
    ErrDet        = '0;
    ErrDet[FLAG]  = ChkEn[FLAG] & flagPend[FLAG_LAT-1] & ~Rx_FlagDetect;
    ErrDet[ABORT] = ChkEn[ABORT] & abortArm & ~Rx_AbortSignal;
    ErrDet[IDLE]  = ChkEn[IDLE] & (idleCnt == IDLE_MAX) & ~Tx_ValidFrame & ~Tx;
  end

endmodule

// File: rtl/hdlc_protocol_monitor.sv
// HDLC protocol monitor: per-channel checkers plus sticky flags, saturating
// error count and first-error capture.
module hdlc_protocol_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned FLAG_LAT = 2,
  parameter int unsigned IDLE_LEN = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CHECKS-1:0]        ChkEn,
  input  logic                         ErrClr,
  hdlc_protocol_monitor_if.slave       Mon,
  output logic [NUM_CHECKS*NUM_CH-1:0] ErrFlags,
  output logic [CNT_W-1:0]             ErrCnt,
  output logic                         FirstErrValid,
  output logic [3:0]                   FirstErrCh,
  output logic [1:0]                   FirstErrCode
);

  localparam int unsigned NUM_ERR = NUM_CHECKS * NUM_CH;
  localparam int unsigned SUM_W   = CNT_W + 7;

  logic [NUM_ERR-1:0] errNow;
  logic [6:0]         errPop;
  logic [SUM_W-1:0]   cntSum;
  logic [CNT_W-1:0]   cntNext;
  logic               errAny;
  logic               found;
  logic               capLoad;
  logic [3:0]         capCh;
  err_code            capCode;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    hdlc_mon_ch #(
      .FLAG_LAT (FLAG_LAT),
      .IDLE_LEN (IDLE_LEN)
    ) u_ch (
      .Clk            (Clk),
      .Rst            (Rst),
      .ChkEn          (ChkEn),
      .Rx             (Mon.Rx[c]),
      .Rx_FlagDetect  (Mon.Rx_FlagDetect[c]),
      .Rx_ValidFrame  (Mon.Rx_ValidFrame[c]),
      .Rx_AbortDetect (Mon.Rx_AbortDetect[c]),
      .Rx_AbortSignal (Mon.Rx_AbortSignal[c]),
      .Tx             (Mon.Tx[c]),
      .Tx_ValidFrame  (Mon.Tx_ValidFrame[c]),
      .ErrDet         (errNow[c*NUM_CHECKS +: NUM_CHECKS])
    );
  end

  // Flat index ch*3+code, so the lowest set bit is lowest channel then FLAG > ABORT > IDLE.
  always_comb begin
    errPop  = '0;
    found   = 1'b0;
    capCh   = '0;
    capCode = FLAG;
    for (int unsigned i = 0; i < NUM_ERR; i++) begin
      errPop = errPop + 7'(errNow[i]);
      if (errNow[i] && !found) begin
        found   = 1'b1;
        capCh   = 4'(i / NUM_CHECKS);
        capCode = err_code'(i % NUM_CHECKS);
      end
    end
    errAny  = |errNow;
    capLoad = errAny & (~FirstErrValid | ErrClr);
    cntSum  = SUM_W'(ErrCnt) + SUM_W'(errPop);
    cntNext = (|cntSum[SUM_W-1:CNT_W]) ? '1 : cntSum[CNT_W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ErrFlags      <= '0;
      ErrCnt        <= '0;
      FirstErrValid <= 1'b0;
      FirstErrCh    <= '0;
      FirstErrCode  <= '0;
    end else begin
      ErrFlags <= (ErrClr ? '0 : ErrFlags) | errNow;
      ErrCnt   <= cntNext;
      if (capLoad) begin
        FirstErrValid <= 1'b1;
        FirstErrCh    <= capCh;
        FirstErrCode  <= capCode;
      end else if (ErrClr) begin
        FirstErrValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/hdlc_protocol_monitor.md
HDLC_PROTOCOL_MONITOR -- requirements
Module: hdlc_protocol_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_CH, 4, number of monitored HDLC channels (1..16)
  FLAG_LAT, 2, required cycles from last flag bit to Rx_FlagDetect (1..7)
  IDLE_LEN, 8, consecutive idle cycles before the Tx idle check arms (1..255)
  CNT_W, 16, width of the saturating error counter
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  Clk  in  1  single clock, all logic on posedge
  Rst  in  1  asynchronous, active-low reset
  ChkEn  in  3  per-check enable [0]=flag [1]=abort [2]=idle
  ErrClr  in  1  one-cycle pulse clearing sticky flags and first-error capture
  Rx  in  NUM_CH  serial receive bit per channel
  Rx_FlagDetect  in  NUM_CH  DUT flag-detected strobe
  Rx_ValidFrame  in  NUM_CH  DUT receive frame-in-progress
  Rx_AbortDetect  in  NUM_CH  DUT raw abort detect
  Rx_AbortSignal  in  NUM_CH  DUT registered abort status
  Tx  in  NUM_CH  serial transmit bit per channel
  Tx_ValidFrame  in  NUM_CH  DUT transmit frame-in-progress
  ErrFlags  out  3*NUM_CH  sticky error flags, bit ch*3+code
  ErrCnt  out  CNT_W  total errors, saturating
  FirstErrValid  out  1  first-error capture holds data
  FirstErrCh  out  4  channel of first error
  FirstErrCode  out  2  check code of first error
REQ-003 Clock is Clk; reset is Rst, asynchronous and active-low.

Function
REQ-004 Per channel, an 8-bit Rx shift history SHALL flag a match when the last 8 received bits, oldest first, are 0,1,1,1,1,1,1,0.
REQ-005 Each match SHALL enter a FLAG_LAT-deep pending pipeline; FLAG error when an entry exits (match cycle + FLAG_LAT) with Rx_FlagDetect low.
REQ-006 Overlapping matches (shared trailing 0) SHALL each be checked independently.
REQ-007 ABORT error SHALL fire in cycle t+1 when Rx_AbortDetect and Rx_ValidFrame were both high in cycle t and Rx_AbortSignal is low in t+1.
REQ-008 Per-channel idle counter: cleared while Tx_ValidFrame high, +1 per cycle while low, saturating at IDLE_LEN.
REQ-009 IDLE error SHALL fire in any cycle where counter equals IDLE_LEN, Tx_ValidFrame low and Tx low.
REQ-010 A disabled check SHALL raise no error; pipelines and counters keep running so re-enabling takes effect next cycle.
REQ-011 Errors SHALL register one cycle after detection: ErrFlags bit set, ErrCnt incremented by the number of errors detected that cycle (0..3*NUM_CH), clamped at 2^CNT_W-1.
REQ-012 ErrClr SHALL clear ErrFlags and FirstErrValid; an error detected in the ErrClr cycle SHALL still be recorded (set wins); ErrCnt SHALL NOT be cleared by ErrClr.
REQ-013 First-error capture SHALL load only when FirstErrValid is low; simultaneous errors resolve to lowest channel, then code FLAG(0) > ABORT(1) > IDLE(2).

Reset
REQ-014 On Rst low: ErrFlags=0, ErrCnt=0, FirstErrValid=0, FirstErrCh=0, FirstErrCode=0, shift histories=8'hFF, pending pipelines=0, abort stage=0, idle counters=0.
REQ-015 Reset mid-operation SHALL discard all pending checks; no error may be reported from pre-reset stimulus.

Structure
REQ-016 Package hdlc_mon_pkg SHALL hold the err_code enum (FLAG=0, ABORT=1, IDLE=2), NUM_CHECKS=3 and FLAG_PATTERN=8'b0111_1110.
REQ-017 Per-channel logic (REQ-004..009) SHALL be sub-module hdlc_mon_ch instantiated NUM_CH times via generate; counting, stickiness and capture stay in the top.

Verification
REQ-018 Ch0 Rx drives 0,1x6,0 with Rx_FlagDetect high 2 cycles after last 0 -> ErrCnt=0, ErrFlags=0.
REQ-019 Same flag on ch2, Rx_FlagDetect withheld -> ErrFlags[6]=1, ErrCnt=1, FirstErrCh=2, FirstErrCode=0.
REQ-020 Ch1 Rx_AbortDetect=Rx_ValidFrame=1 one cycle, Rx_AbortSignal stays 0 -> ErrFlags[4]=1, ErrCnt=1; repeat with Rx_AbortSignal=1 -> no new error.
REQ-021 Ch3 Tx_ValidFrame=0 for 12 cycles, Tx=0 at cycle 10 -> IDLE error (ErrFlags[11]); Tx=0 at cycle 5 -> no error.
REQ-022 Same-cycle FLAG on ch3 and ABORT on ch1 with ErrClr pulsed -> ErrCnt+=2, FirstErrCh=1, FirstErrCode=1, both flags set; CNT_W=4 with 20 errors -> ErrCnt=15.
REQ-023 Rst low for 1 cycle between a flag match and its FLAG_LAT check -> no error, all outputs at REQ-014 values.
